// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings and default width shared by the HI/LO multiply/divide unit
package mdu_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division iteration
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q
);
  logic [WIDTH:0] t;
  // rem < dvs keeps the trial difference in WIDTH+1 bits, so the top bit is the borrow
  assign t = {rem, din} - {1'b0, dvs};
  assign q = ~t[WIDTH];
  assign rem_next = q ? t[WIDTH-1:0] : {rem[WIDTH-2:0], din};
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative mult/div unit with HI/LO registers; MDU_FAST_MULT_EN adds a single-cycle multiplier
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] am, bm, aa, ba, rem_nx, quo, rmd;
  logic [2*WIDTH-1:0] acc, prod, fprod;
  logic [WIDTH:0] madd;
  logic is_div, neg, rsign, sgn, qb, fast;
  assign sgn = op == OP_MULT || op == OP_DIV;
  assign aa = sgn && a[WIDTH-1] ? -a : a;
  assign ba = sgn && b[WIDTH-1] ? -b : b;
  assign busy = state != IDLE;
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] ae, be;
  assign ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
  assign be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
  assign fprod = ae * be;
  assign fast = state == IDLE && start && !op[1];
`else
  assign fprod = '0;
  assign fast = 1'b0;
`endif
  mdu_divstep #(.WIDTH(WIDTH)) u_step (
    .rem(acc[2*WIDTH-1:WIDTH]),
    .din(acc[WIDTH-1]),
    .dvs(bm),
    .rem_next(rem_nx),
    .q(qb)
  );
  assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, am} : '0);
  assign prod = neg ? -acc : acc;
  assign quo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rmd = rsign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_comb begin
    state_nx = state == IDLE ? (start && !fast ? RUN : IDLE)
             : state == RUN ? (cnt == CNT_W'(WIDTH-1) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      am     <= '0;
      bm     <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      rsign  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == FIX || fast;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (fast) {hi, lo} <= fprod;
        else if (start) begin
          am     <= aa;
          bm     <= ba;
          acc    <= {{WIDTH{1'b0}}, op[1] ? aa : ba};
          is_div <= op[1];
          neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          rsign  <= sgn & a[WIDTH-1];
          cnt    <= '0;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? {rem_nx, acc[WIDTH-2:0], qb} : {madd, acc[WIDTH-1:1]};
      end else if (!is_div) {hi, lo} <= prod;
      // |a| re-signed reproduces the raw dividend for divide by zero
      else if (bm == '0) begin
        hi <= rsign ? -am : am;
        lo <= '1;
      end else begin
        hi <= rmd;
        lo <= quo;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench for mdu_hilo; honours MDU_FAST_MULT_EN for multiply latency
module tb_mdu_hilo;
  logic clock = 1'b0, resetn = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  typedef struct {string tag; logic [31:0] h; logic [31:0] l;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'b00) return sx * sy;
    if (o == 2'b01) return {32'b0, x} * {32'b0, y};
    if (y == 0) return {x, 32'hffffffff};
    if (o == 2'b11) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hffffffff) return {32'h0, 32'h80000000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction
  always @(negedge clock) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = exp_q.pop_front();
        chk({e.tag, "_hi"}, hi, e.h);
        chk({e.tag, "_lo"}, lo, e.l);
      end
    end
  end
  // caller sits at a negedge; returns at the negedge of the done cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input string tag, input int inj);
    int n, lat;
    bit bok;
    lat = 34;
`ifdef MDU_FAST_MULT_EN
    if (!o[1]) lat = 1;
`endif
    exp_q.push_back('{tag, eh, el});
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    n = 1; bok = 1'b1;
    @(negedge clock);
    while (!done && n < 100) begin
      bok &= busy;
      if (n == inj) begin start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hdeadbeef; end
      @(posedge clock); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      n++;
      @(negedge clock);
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy_run"}, bok, 1);
    chk({tag, "_busy_done"}, busy, 0);
  endtask
  initial begin
    logic [63:0] m;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    logic [31:0] pick [6];
    pick = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h5};
    repeat (2) @(negedge clock);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    resetn = 1'b1;
    @(negedge clock);
    run_op(2'b01, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, "multu_max", 0);
    run_op(2'b00, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb, "mult_neg", 0);
    run_op(2'b10, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd, "div_neg", 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu", 5);
    run_op(2'b11, 32'h64, 32'h0, 32'h64, 32'hffffffff, "divu_zero", 0);
    run_op(2'b10, 32'hfffffff9, 32'h0, 32'hfffffff9, 32'hffffffff, "div_zero", 0);
    run_op(2'b10, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000, "div_ovf", 0);
    run_op(2'b00, 32'd6, 32'hfffffff9, 32'hffffffff, 32'hffffffd6, "mult_inj", 7);
    @(negedge clock);
    chk("done_single", done, 0);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hcafef00d;
    @(posedge clock); #1;
    lo_we = 1'b0;
    @(negedge clock);
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'hcafef00d);
    op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "multu_after_rst", 0);
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom_range(0, 1) ? pick[$urandom_range(0, 5)] : $urandom;
      rb = $urandom_range(0, 1) ? pick[$urandom_range(0, 5)] : $urandom;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], $sformatf("rand%0d_op%0d", i, ro), 0);
    end
    @(negedge clock);
    chk("idle_done", done, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
